logic_unit_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's two-input gate block.
- Applies one of eight bitwise operations to WIDTH-bit operands, selected per transaction by an opcode.
- Computes zero and parity flags and counts delivered results.
- Sits between a valid/ready producer and consumer. It is a 2-stage pipeline with full throughput and backpressure.

---
 rtl/logic_unit_pkg.sv | 13 +
 rtl/logic_op_core.sv | 31 +++
 rtl/logic_unit_pipe.sv | 108 ++++++++++
 tb/tb_logic_unit_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Opcode constants and type shared by the logic-unit pipeline and its combinational core.
package logic_unit_pkg;
  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'd0;
  localparam op_t OP_OR   = 3'd1;
  localparam op_t OP_XOR  = 3'd2;
  localparam op_t OP_NOTA = 3'd3;
  localparam op_t OP_NOTB = 3'd4;
  localparam op_t OP_NAND = 3'd5;
  localparam op_t OP_NOR  = 3'd6;
  localparam op_t OP_XNOR = 3'd7;
endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise operator with zero and parity flags.
module logic_op_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity
);
  always_comb begin
    result = '0;
    unique case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOTA: result = ~a;
      OP_NOTB: result = ~b;
      OP_NAND: result = ~(a & b);
      OP_NOR:  result = ~(a | b);
      OP_XNOR: result = ~(a ^ b);
      default: result = '0;
    endcase
  end

  assign zero   = (result == '0);
  assign parity = ^result;
endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit: operand register, result register,
// and a saturating count of delivered results.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       op_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] res_out,
  output logic             zero_out,
  output logic             par_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt_out
);
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  op_t              s1_op_q, s1_op_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d, par_q, par_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s1_adv, in_xfer, out_xfer;
  logic [WIDTH-1:0] core_res;
  logic             core_zero, core_par;

  // Stage 2 moves whenever it is empty or being drained; stage 1 follows it.
  assign s1_adv   = !s2_valid_q | out_ready;
  assign in_ready = !s1_valid_q | s1_adv;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = s2_valid_q & out_ready;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a_q),
    .b      (s1_b_q),
    .op     (s1_op_q),
    .result (core_res),
    .zero   (core_zero),
    .parity (core_par)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_a_d     = a_in;
      s1_b_d     = b_in;
      s1_op_d    = op_t'(op_in);
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    zero_d     = zero_q;
    par_d      = par_q;
    if (s1_adv) begin
      s2_valid_d = s1_valid_q;
      res_d      = core_res;
      zero_d     = core_zero;
      par_d      = core_par;
    end

    cnt_d = cnt_q;
    if (out_xfer && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_AND;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      par_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      zero_q     <= zero_d;
      par_q      <= par_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign res_out   = res_q;
  assign zero_out  = zero_q;
  assign par_out   = par_q;
  assign cnt_out   = cnt_q;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe (WIDTH=8, CNT_W=4) plus WIDTH=1 / WIDTH=64 NAND builds.
module tb_logic_unit_pipe;
  logic       clk, rst_n;
  logic [7:0] a_in, b_in, res_out;
  logic [2:0] op_in;
  logic       in_valid, in_ready, zero_out, par_out, out_valid, out_ready;
  logic [3:0] cnt_out;

  logic        a1, b1, r1, z1, p1, ir1, ov1;
  logic [63:0] a64, b64, r64;
  logic        z64, p64, ir64, ov64;
  logic [15:0] c1, c64;
  logic [2:0]  opw;
  logic        ivw;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp8 [8] = '{8'h24, 8'hBD, 8'h99, 8'h5A, 8'hC3, 8'hDB, 8'h42, 8'h66};

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .op_in(op_in),
    .in_valid(in_valid), .in_ready(in_ready), .res_out(res_out),
    .zero_out(zero_out), .par_out(par_out), .out_valid(out_valid),
    .out_ready(out_ready), .cnt_out(cnt_out)
  );

  logic_unit_pipe #(.WIDTH(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .a_in(a1), .b_in(b1), .op_in(opw),
    .in_valid(ivw), .in_ready(ir1), .res_out(r1), .zero_out(z1), .par_out(p1),
    .out_valid(ov1), .out_ready(1'b1), .cnt_out(c1)
  );

  logic_unit_pipe #(.WIDTH(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .a_in(a64), .b_in(b64), .op_in(opw),
    .in_valid(ivw), .in_ready(ir64), .res_out(r64), .zero_out(z64), .par_out(p64),
    .out_valid(ov64), .out_ready(1'b1), .cnt_out(c64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~a;
      3'd4: return ~b;
      3'd5: return ~(a & b);
      3'd6: return ~(a | b);
      default: return ~(a ^ b);
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] ca, cb, ev;
    logic [2:0] cop;
    int sent, got;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; op_in = '0;
    a1 = 1'b0; b1 = 1'b0; a64 = '0; b64 = '0; opw = '0; ivw = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_res",       64'(res_out),   64'd0);
    chk("rst_zero",      64'(zero_out),  64'd0);
    chk("rst_par",       64'(par_out),   64'd0);
    chk("rst_cnt",       64'(cnt_out),   64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    #10 rst_n = 1'b1;
    tick();

    // All eight opcodes back-to-back, consumer always ready.
    out_ready = 1'b1; a_in = 8'hA5; b_in = 8'h3C;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 8);
      op_in    = 3'(c);
      #1;
      chk("ops_in_ready", 64'(in_ready), 64'd1);
      tick();
      if (c == 0) chk("ops_latency", 64'(out_valid), 64'd0);
      else if (c <= 8) begin
        chk("ops_valid", 64'(out_valid), 64'd1);
        chk("ops_res",   64'(res_out),   64'(exp8[c-1]));
        chk("ops_par",   64'(par_out),   64'(^exp8[c-1]));
      end else chk("ops_drain", 64'(out_valid), 64'd0);
    end
    chk("ops_cnt", 64'(cnt_out), 64'd8);

    // Zero / parity flags.
    in_valid = 1'b1; op_in = 3'd2; a_in = 8'h5F; b_in = 8'h5F;
    tick(); in_valid = 1'b0; tick();
    chk("zp_xor_res",  64'(res_out),  64'h00);
    chk("zp_xor_zero", 64'(zero_out), 64'd1);
    chk("zp_xor_par",  64'(par_out),  64'd0);
    in_valid = 1'b1; op_in = 3'd1; a_in = 8'h01; b_in = 8'h02;
    tick(); in_valid = 1'b0; tick();
    chk("zp_or_res",  64'(res_out),  64'h03);
    chk("zp_or_zero", 64'(zero_out), 64'd0);
    chk("zp_or_par",  64'(par_out),  64'd0);
    tick();

    // Backpressure: two accepted, third stalls until the consumer frees a slot.
    do_reset();
    out_ready = 1'b0; op_in = 3'd2; b_in = 8'h00;
    in_valid = 1'b1; a_in = 8'h10; #1;
    chk("bp_rdy0", 64'(in_ready), 64'd1);
    tick(); a_in = 8'h11; #1;
    chk("bp_rdy1", 64'(in_ready), 64'd1);
    tick(); a_in = 8'h12; #1;
    chk("bp_rdy2_low", 64'(in_ready), 64'd0);
    chk("bp_res_a", 64'(res_out), 64'h10);
    tick();
    chk("bp_res_b",   64'(res_out),   64'h10);
    chk("bp_valid",   64'(out_valid), 64'd1);
    chk("bp_rdy_hold", 64'(in_ready), 64'd0);
    chk("bp_cnt_hold", 64'(cnt_out),  64'd0);
    out_ready = 1'b1; #1;
    chk("bp_rdy_comb", 64'(in_ready), 64'd1);
    tick(); in_valid = 1'b0;
    chk("bp_out1", 64'(res_out), 64'h11);
    tick();
    chk("bp_out2", 64'(res_out), 64'h12);
    tick();
    chk("bp_empty", 64'(out_valid), 64'd0);
    chk("bp_cnt",   64'(cnt_out),   64'd3);

    // Full-rate stream with random stalls against a scoreboard.
    sent = 0; got = 0;
    ca = 8'($urandom); cb = 8'($urandom); cop = 3'($urandom);
    for (int c = 0; c < 400 && got < 20; c++) begin
      in_valid = (sent < 20); a_in = ca; b_in = cb; op_in = cop;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          ev = q.pop_front();
          chk("sb_res",  64'(res_out),  64'(ev));
          chk("sb_zero", 64'(zero_out), 64'(ev == 8'h00));
          chk("sb_par",  64'(par_out),  64'(^ev));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_op(cop, ca, cb));
        sent++;
        ca = 8'($urandom); cb = 8'($urandom); cop = 3'($urandom);
      end
      tick();
    end
    chk("sb_received", 64'(got), 64'd20);
    chk("sb_cnt_sat",  64'(cnt_out), 64'd15);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("sb_cnt_hold", 64'(cnt_out), 64'd15);

    // Asynchronous reset between edges with both stages full.
    out_ready = 1'b0; in_valid = 1'b1;
    op_in = 3'd1; a_in = 8'hF0; b_in = 8'h0F;
    tick(); op_in = 3'd2; a_in = 8'h0F; b_in = 8'h00;
    tick(); in_valid = 1'b0;
    chk("mr_full", 64'(out_valid), 64'd1);
    chk("mr_pre_res", 64'(res_out), 64'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_res",   64'(res_out),   64'd0);
    chk("mr_par",   64'(par_out),   64'd0);
    chk("mr_cnt",   64'(cnt_out),   64'd0);
    #2 rst_n = 1'b1;
    tick();
    out_ready = 1'b1; in_valid = 1'b1; op_in = 3'd0; a_in = 8'hFF; b_in = 8'h3C;
    tick(); in_valid = 1'b0;
    chk("mr_lat1", 64'(out_valid), 64'd0);
    tick();
    chk("mr_lat2", 64'(out_valid), 64'd1);
    chk("mr_new_res", 64'(res_out), 64'h3C);

    // WIDTH=1 and WIDTH=64 builds: NAND of all-ones.
    ivw = 1'b1; opw = 3'd5; a1 = 1'b1; b1 = 1'b1; a64 = '1; b64 = '1;
    tick(); ivw = 1'b0; tick();
    chk("w1_valid",  64'(ov1),  64'd1);
    chk("w1_res",    64'(r1),   64'd0);
    chk("w1_zero",   64'(z1),   64'd1);
    chk("w64_valid", 64'(ov64), 64'd1);
    chk("w64_res",   r64,       64'd0);
    chk("w64_zero",  64'(z64),  64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
